// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic valid/ready stage register carrying pc, exception, payload and delay-slot flag.
// Define PIPE_STAGE_SKID_EN for a 2-entry skid buffer with registered in_ready; default is a single register.
module pipe_stage_elastic #(
  parameter int               DATA_W      = 82,
  parameter int               PC_W        = 32,
  parameter int               EXC_W       = 5,
  parameter logic [EXC_W-1:0] EXC_NONE    = '0,
  parameter int               NXT_DLY_BIT = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dly,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [EXC_W-1:0]  out_exc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_dly,
  output logic              out_next_dly,
  output logic [1:0]        occ
);
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [EXC_W-1:0]  exc;
    logic [DATA_W-1:0] data;
    logic              dly;
  } entry_t;
  entry_t in_e, head_q, head_d;
  logic   push, pop;
  assign in_e = {in_pc, in_exc, in_data, in_dly};
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state_q, state_d;
  entry_t skid_q, skid_d;
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q != EMPTY;
  assign occ       = state_q;
  // Next state: head/skid slot movement per handshake; flush empties everything.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (push) begin
        head_d  = in_e;
        state_d = ONE;
      end
      ONE: begin
        if (push && !pop) begin
          skid_d  = in_e;
          state_d = FULL;
        end else if (pop && !push) begin
          head_d  = '0;
          state_d = EMPTY;
        end else if (push && pop) head_d = in_e;
      end
      FULL: if (pop) begin
        head_d  = skid_q;
        skid_d  = '0;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end
  end
  // State and slot registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end
`else
  logic valid_q, valid_d;
  assign in_ready  = !valid_q | out_ready;
  assign out_valid = valid_q;
  assign occ       = {1'b0, valid_q};
  // Next state: push (possibly replacing a popped head) fills, lone pop or flush empties.
  always_comb begin
    valid_d = flush ? 1'b0 : push ? 1'b1 : pop ? 1'b0 : valid_q;
    head_d  = flush ? '0 : push ? in_e : pop ? '0 : head_q;
  end
  // Head register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end
`endif
  assign out_pc       = out_valid ? head_q.pc : '0;
  assign out_exc      = out_valid ? head_q.exc : EXC_NONE;
  assign out_data     = out_valid ? head_q.data : '0;
  assign out_dly      = out_valid & head_q.dly;
  assign out_next_dly = out_data[NXT_DLY_BIT];
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: scoreboard bench for pipe_stage_elastic (either PIPE_STAGE_SKID_EN build).
module tb_pipe_stage_elastic;
  localparam int DATA_W = 82, PC_W = 32, EXC_W = 5;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [EXC_W-1:0]  exc;
    logic [DATA_W-1:0] data;
    logic              dly;
  } ent_t;
  logic clk = 0, resetn, flush, in_valid, in_ready, in_dly, out_valid, out_ready, out_dly, out_next_dly;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [EXC_W-1:0] in_exc, out_exc;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0] occ;
  ent_t sb[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipe_stage_elastic dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_exc(in_exc), .in_data(in_data), .in_dly(in_dly),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_exc(out_exc),
    .out_data(out_data), .out_dly(out_dly), .out_next_dly(out_next_dly), .occ(occ)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    int   n;
    logic exp_rdy, push, pop;
    ent_t cur, hd;
    @(negedge clk);
    n = sb.size();
    exp_rdy = (CAP == 2) ? (n < 2) : (n == 0 || out_ready);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, n != 0);
    chk("occ", occ, n);
    hd = (n != 0) ? sb[0] : '0;
    chk("out_pc", out_pc, hd.pc);
    chk("out_exc", out_exc, hd.exc);
    chk("out_data", out_data, hd.data);
    chk("out_dly", out_dly, hd.dly);
    chk("out_next_dly", out_next_dly, hd.data[0]);
    cur = {in_pc, in_exc, in_data, in_dly};
    push = in_valid && exp_rdy;
    pop = n != 0 && out_ready;
    @(posedge clk);
    if (!resetn || flush) sb.delete();
    else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(cur);
    end
    #1;
  endtask
  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic [EXC_W-1:0] exc,
                       input logic [DATA_W-1:0] data, input logic dly);
    in_valid = v; in_pc = pc; in_exc = exc; in_data = data; in_dly = dly;
  endtask
  initial begin
    resetn = 0; flush = 0; out_ready = 1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1;
    tick();
    chk("reset_in_ready", in_ready, 1'b1);
    drive(1, 32'hBFC0_0000, 0, 82'h5A, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("first_pc", out_pc, 32'hBFC0_0000);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h100 + 4 * i, 0, 82'(i + 16), 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    out_ready = 0;
    drive(1, 32'h200, 0, 82'h2, 0); tick();
    drive(1, 32'h204, 0, 82'h4, 0); tick();
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    chk("hold_pc", out_pc, 32'h200);
    out_ready = 1;
    tick(); tick(); tick();
    out_ready = 0;
    drive(1, 32'h2F0, 3, 82'h8, 0); tick();
    flush = 1;
    drive(1, 32'h300, 5'h0C, 82'h9, 1); tick();
    flush = 0;
    drive(0, 0, 0, 0, 0);
    chk("flush_occ", occ, 2'd0);
    tick();
    out_ready = 1;
    drive(1, 32'h400, 0, {81'h1234, 1'b1}, 1); tick();
    drive(0, 0, 0, 0, 0);
    chk("next_dly", out_next_dly, 1'b1);
    tick();
    out_ready = 0;
    drive(1, 32'h500, 7, 82'hA, 1); tick();
    drive(1, 32'h504, 9, 82'hB, 0); tick();
    drive(0, 0, 0, 0, 0);
    resetn = 0; tick();
    resetn = 1; out_ready = 1;
    chk("rst_occ", occ, 2'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    tick();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom, 5'($urandom), {$urandom, $urandom, $urandom}, 1'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      tick();
    end
    flush = 0;
    drive(0, 0, 0, 0, 0);
    out_ready = 1;
    tick(); tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
